// File: rtl/mw_addsub_pkg.sv
// mw_addsub_pkg: shared state encoding, default limb width and index-width helper for mw_addsub_seq
package mw_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
  localparam int DEF_G = 32;
  function automatic int idx_w(input int limbs);
    return (limbs > 1) ? $clog2(limbs) : 1;
  endfunction
endpackage

// File: rtl/addsub_limb.sv
// addsub_limb: combinational G-bit add/sub slice with carry-out and carry into the MSB
module addsub_limb #(
  parameter int G = 32
) (
  input  logic [G-1:0] x,
  input  logic [G-1:0] y,
  input  logic         mode,
  input  logic         ci,
  output logic [G-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [G-1:0] y_eff;
  // sum with optional inversion of y; MSB carry-in recovered from the MSB sum bit
  always_comb begin
    y_eff = mode ? ~y : y;
    {co, s} = {1'b0, x} + {1'b0, y_eff} + {{G{1'b0}}, ci};
    c_msb = s[G-1] ^ x[G-1] ^ y_eff[G-1];
  end
endmodule

// File: rtl/mw_addsub_seq.sv
// mw_addsub_seq: multi-word add/sub sequencer, one limb per clock (optional ovf output via MW_ADDSUB_OVF_EN)
module mw_addsub_seq
  import mw_addsub_pkg::*;
#(
  parameter int G     = DEF_G,
  parameter int LIMBS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [G*LIMBS-1:0]   a,
  input  logic [G*LIMBS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [G*LIMBS-1:0]   result,
`ifdef MW_ADDSUB_OVF_EN
  output logic                 ovf,
`endif
  output logic                 carry
);
  localparam int W  = G * LIMBS;
  localparam int IW = idx_w(LIMBS);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic mode_q, mode_d, c_q, c_d;
  logic [G-1:0] s;
  logic co, last;
`ifdef MW_ADDSUB_OVF_EN
  logic c_msb, ovf_q, ovf_d;
`else
  logic c_msb_unused;
`endif
  addsub_limb #(.G(G)) u_limb (
    .x    (a_q[idx_q*G +: G]),
    .y    (b_q[idx_q*G +: G]),
    .mode (mode_q),
    .ci   (c_q),
    .s    (s),
    .co   (co),
`ifdef MW_ADDSUB_OVF_EN
    .c_msb(c_msb)
`else
    .c_msb(c_msb_unused)
`endif
  );
  assign last      = idx_q == IW'(LIMBS - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign result    = res_q;
  assign carry     = c_q;
  // next-state: capture in IDLE, one limb per RUN cycle, wait for consumer in HOLD
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        mode_d  = mode;
        c_d     = cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx_q*G +: G] = s;
        c_d     = co;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? HOLD : RUN;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      res_q   <= res_d;
    end
  end
`ifdef MW_ADDSUB_OVF_EN
  assign ovf   = ovf_q;
  assign ovf_d = (state_q == RUN && last) ? (c_msb ^ co) : ovf_q;
  // signed overflow captured from the top limb, held through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
`endif
endmodule
